// File: rtl/scmi_db_pkg.sv
// rtl/scmi_db_pkg.sv - shared defaults, channel ID type and priority encoder for the doorbell queue
package scmi_db_pkg;
  localparam int NUM_CH_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CH_ID_W        = $clog2(NUM_CH_DEF);
  localparam int ENC_W          = 64;

  typedef logic [CH_ID_W-1:0] ch_id_t;

  // Index of the lowest set bit, 0 when nothing is set; callers zero-extend to ENC_W.
  function automatic int lowest_set(input logic [ENC_W-1:0] v);
    lowest_set = 0;
    for (int i = ENC_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = i;
    end
  endfunction
endpackage

// File: rtl/scmi_db_id_fifo.sv
// rtl/scmi_db_id_fifo.sv - registered channel-ID FIFO, no fall-through, head forced to 0 when empty
module scmi_db_id_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable at equal indices.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~w_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign o_valid = ~w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/scmi_db_irq_queue.sv
// rtl/scmi_db_irq_queue.sv - doorbell edge capture, pending/coalesce tracking and ordered ID queue
// Optional input synchroniser enabled by defining SCMI_DB_SYNC_EN.
module scmi_db_irq_queue
  import scmi_db_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH-1:0]         db_irq_i,
  input  logic [NUM_CH-1:0]         mask_i,
  output logic                      ch_valid_o,
  output logic [$clog2(NUM_CH)-1:0] ch_id_o,
  input  logic                      ch_ready_i,
  output logic                      irq_o,
  output logic [NUM_CH-1:0]         pending_o,
  output logic                      overflow_o,
  input  logic                      clr_overflow_i
);
  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] w_db;
  logic [NUM_CH-1:0] w_edge;
  logic [NUM_CH-1:0] w_take;
  logic [NUM_CH-1:0] r_prev;
  logic [NUM_CH-1:0] r_pending;
  logic [ID_W-1:0]   w_sel;
  logic              w_full;
  logic              w_load;
  logic              w_pop;
  logic              r_overflow;

  if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || NUM_CH > ENC_W)
  begin : g_bad_cfg
    $error("scmi_db_irq_queue: unsupported parameter set");
  end

`ifdef SCMI_DB_SYNC_EN
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], db_irq_i};
  end

  assign w_db = r_sync[SYNC_STAGES-1];
`else
  assign w_db = db_irq_i;
`endif

  assign w_edge = w_db & ~r_prev & mask_i;
  assign w_load = !w_full && (r_pending != '0);
  assign w_sel  = ID_W'(lowest_set(ENC_W'(r_pending)));
  assign w_take = w_load ? (NUM_CH'(1) << w_sel) : '0;
  assign w_pop  = ch_valid_o & ch_ready_i;

  // A fresh edge re-sets pending even on the bit being loaded this cycle; only
  // an edge landing on a pending bit that stays put counts as a coalesced ring.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prev     <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev     <= w_db;
      r_pending  <= (r_pending & ~w_take) | w_edge;
      r_overflow <= (|(w_edge & r_pending & ~w_take)) | (r_overflow & ~clr_overflow_i);
    end
  end

  scmi_db_id_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_W)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_load),
    .i_data  (w_sel),
    .i_pop   (w_pop),
    .o_data  (ch_id_o),
    .o_valid (ch_valid_o),
    .o_full  (w_full)
  );

  assign irq_o      = ch_valid_o;
  assign pending_o  = r_pending;
  assign overflow_o = r_overflow;
endmodule
